round_key_store: RTL and testbench

ROUND_KEY_STORE -- requirements
Module: round_key_store

---
 rtl/round_key_store.sv | 161 ++++++++++++++++
 tb/tb_round_key_store.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_key_store.sv
// AES-128 round-key store: expands a cipher key into 11 round keys,
// one round per clock, and serves them on a combinational read port.
// Ports: clk, rst_n (async, active-low); key_valid/key_ready/key_in
// accept a cipher key; rd_idx/rd_key read a round key;
// keys_ready flags a complete schedule; busy flags expansion.
module round_key_store #(
  parameter bit REVERSE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
  output logic         keys_ready,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at the top for b=0, so the bit offset is (255-b)*8.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    c = 8'h00;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [127:0] expand(
    input logic [127:0] k,
    input logic [3:0]   r
  );
    logic [31:0] w0, w1, w2, w3, rw, t;
    logic [31:0] n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    rw = {w3[23:0], w3[31:24]};
    t  = {sbox(rw[31:24]), sbox(rw[23:16]),
          sbox(rw[15:8]),  sbox(rw[7:0])};
    t  = t ^ {rcon(r), 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_t       state, state_nxt;
  logic [3:0]   cnt;
  logic [127:0] slot [11];
  logic [127:0] prev_key;
  logic [127:0] next_key;
  logic [3:0]   phys;
  logic         accept;

  assign accept = key_valid & key_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = EXPAND;
      EXPAND:  if (cnt == 4'd10) state_nxt = DONE;
      DONE:    if (accept) state_nxt = EXPAND;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    key_ready  = 1'b1;
    busy       = 1'b0;
    keys_ready = 1'b0;
    unique case (state)
      IDLE:    ;
      EXPAND: begin
        key_ready = 1'b0;
        busy      = 1'b1;
      end
      DONE:    keys_ready = 1'b1;
      default: ;
    endcase
  end

  // Single expansion datapath: source is the slot just below cnt.
  always_comb begin
    prev_key = '0;
    for (int i = 0; i < 10; i++)
      if (cnt == 4'(i + 1)) prev_key = slot[i];
  end

  assign next_key = expand(prev_key, cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
      for (int i = 0; i < 11; i++) slot[i] <= '0;
    end else if (accept) begin
      slot[0] <= key_in;
      cnt     <= 4'd1;
    end else if (state == EXPAND) begin
      for (int i = 1; i < 11; i++)
        if (cnt == 4'(i)) slot[i] <= next_key;
      if (cnt != 4'd10) cnt <= cnt + 4'd1;
    end
  end

  always_comb begin
    phys   = REVERSE ? (4'd10 - rd_idx) : rd_idx;
    rd_key = '0;
    if (rd_idx <= 4'd10)
      for (int i = 0; i < 11; i++)
        if (phys == 4'(i)) rd_key = slot[i];
  end

endmodule

// File: tb/tb_round_key_store.sv
// Bench for round_key_store: key-level schedule model, checked on
// both read orders every cycle, plus FIPS-197 literal vectors.
module tb_round_key_store;

  localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z1   = 128'h62636363626363636263636362636363;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic [127:0] key_in;
  logic [3:0]   rd_idx;
  logic         kr0, kr1, ks0, ks1, bz0, bz1;
  logic [127:0] rk0, rk1;

  int checks = 0;
  int errors = 0;
  int ncyc;

  logic [7:0] sb [256];

  // model: 0 idle, 1 expanding, 2 done
  int           m_st;
  int           m_prog;
  logic [127:0] m_key, m_prev;
  bit           m_cur_z, m_prev_z;

  round_key_store #(.REVERSE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid),
    .key_ready(kr0), .key_in(key_in), .rd_idx(rd_idx),
    .rd_key(rk0), .keys_ready(ks0), .busy(bz0)
  );

  round_key_store #(.REVERSE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid),
    .key_ready(kr1), .key_in(key_in), .rd_idx(rd_idx),
    .rd_key(rk1), .keys_ready(ks1), .busy(bz1)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] a, int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  // S-box from GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2)
            ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] round_key(logic [127:0] key, int n);
    logic [127:0] k;
    logic [31:0]  w0, w1, w2, w3, t;
    logic [7:0]   rc;
    k  = key;
    rc = 8'h01;
    for (int r = 1; r <= n; r++) begin
      w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
      t  = {w3[23:0], w3[31:24]};
      t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
      t  = t ^ {rc, 24'h0};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      k  = {w0, w1, w2, w3};
      rc = xt(rc);
    end
    return k;
  endfunction

  function automatic logic [127:0] exp_slot(int i);
    if (i < 0 || i > 10) return '0;
    if (m_cur_z) return '0;
    if (i <= m_prog) return round_key(m_key, i);
    if (m_prev_z) return '0;
    return round_key(m_prev, i);
  endfunction

  task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st     <= 0;
      m_prog   <= 0;
      m_key    <= '0;
      m_prev   <= '0;
      m_cur_z  <= 1'b1;
      m_prev_z <= 1'b1;
    end else if (key_valid && m_st != 1) begin
      m_prev   <= m_key;
      m_prev_z <= m_cur_z;
      m_key    <= key_in;
      m_cur_z  <= 1'b0;
      m_prog   <= 0;
      m_st     <= 1;
    end else if (m_st == 1) begin
      m_prog <= m_prog + 1;
      if (m_prog == 9) m_st <= 2;
    end
  end

  always @(negedge clk) begin
    check("key_ready0", 128'(kr0), 128'(m_st != 1));
    check("key_ready1", 128'(kr1), 128'(m_st != 1));
    check("busy0", 128'(bz0), 128'(m_st == 1));
    check("busy1", 128'(bz1), 128'(m_st == 1));
    check("keys_ready0", 128'(ks0), 128'(m_st == 2));
    check("keys_ready1", 128'(ks1), 128'(m_st == 2));
    check("rd_key_fwd", rk0, exp_slot(int'(rd_idx)));
    check("rd_key_rev", rk1,
          (rd_idx > 10) ? 128'h0 : exp_slot(10 - int'(rd_idx)));
  end

  task automatic step();
    @(posedge clk);
    #1;
    rd_idx = 4'($urandom_range(0, 15));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic offer(logic [127:0] k);
    step();
    key_valid = 1'b1;
    key_in    = k;
    step();
    key_valid = 1'b0;
    key_in    = rnd128();
  endtask

  task automatic wait_done();
    while (!ks0 && ncyc < 20) begin
      step();
      ncyc++;
    end
    if (!ks0) begin
      errors++;
      $display("FAIL done_timeout: got busy after %0d required 10", ncyc);
    end
  endtask

  task automatic lit(int idx, logic [127:0] e0, logic [127:0] e1);
    rd_idx = 4'(idx);
    #1;
    check($sformatf("lit_fwd_%0d", idx), rk0, e0);
    check($sformatf("lit_rev_%0d", idx), rk1, e1);
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    rd_idx    = 4'd0;
    build_sbox();
    check("model_rk1", round_key(FIPS, 1), RK1);
    check("model_rk10", round_key(FIPS, 10), RK10);
    check("model_z1", round_key('0, 1), Z1);
    #1;
    check("rst_key_ready", 128'(kr0), 128'd1);
    check("rst_busy", 128'(bz0), 128'd0);
    check("rst_keys_ready", 128'(ks0), 128'd0);
    for (int i = 0; i < 16; i++) lit(i, 128'h0, 128'h0);
    repeat (2) step();
    rst_n = 1'b1;

    // FIPS key, with an ignored offer in the middle of expansion
    offer(FIPS);
    ncyc = 0;
    repeat (3) begin step(); ncyc++; end
    check("exp_key_ready", 128'(kr0), 128'd0);
    key_valid = 1'b1;
    key_in    = rnd128();
    step();
    ncyc++;
    key_valid = 1'b0;
    wait_done();
    check("fips_cycles", 128'(ncyc), 128'd10);
    lit(0, FIPS, RK10);
    lit(1, RK1, round_key(FIPS, 9));
    lit(10, RK10, FIPS);
    lit(12, 128'h0, 128'h0);

    // all-zero key
    offer('0);
    ncyc = 0;
    wait_done();
    check("zero_cycles", 128'(ncyc), 128'd10);
    lit(0, 128'h0, round_key('0, 10));
    lit(1, Z1, round_key('0, 9));
    lit(9, round_key('0, 9), Z1);

    // restart from DONE
    offer(FIPS);
    check("restart_keys_ready", 128'(ks0), 128'd0);
    ncyc = 0;
    while (!ks0 && ncyc < 20) begin
      @(posedge clk);
      #1;
      rd_idx = 4'd12;
      ncyc++;
    end
    check("restart_cycles", 128'(ncyc), 128'd10);
    lit(1, RK1, round_key(FIPS, 9));

    // key_valid held high: re-accept on every DONE cycle
    step();
    key_valid = 1'b1;
    repeat (25) begin
      key_in = rnd128();
      step();
    end
    key_valid = 1'b0;
    ncyc = 0;
    wait_done();

    // reset during the fifth expansion cycle
    offer(rnd128());
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 128'(bz0), 128'd0);
    check("abort_keys_ready", 128'(ks0), 128'd0);
    for (int i = 0; i < 16; i++) lit(i, 128'h0, 128'h0);
    step();
    rst_n = 1'b1;
    offer(FIPS);
    ncyc = 0;
    wait_done();
    check("post_abort_cycles", 128'(ncyc), 128'd10);
    lit(1, RK1, round_key(FIPS, 9));

    // random traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      step();
      key_valid = ($urandom_range(0, 5) == 0);
      key_in    = rnd128();
      rst_n     = ($urandom_range(0, 149) != 0);
    end
    rst_n     = 1'b1;
    key_valid = 1'b0;
    repeat (15) step();
    check("final_keys_ready", 128'(ks0), 128'(m_st == 2));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
